multiply_divide_unit: RTL and testbench

//  Multi-cycle MIPS multiply/divide unit that owns the architectural HI/LO registers.

---
 rtl/multiply_divide_unit_pkg.sv | 45 ++++
 rtl/mdu_divider_core.sv | 49 ++++
 rtl/multiply_divide_unit.sv | 174 +++++++++++++++++
 tb/tb_multiply_divide_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiply_divide_unit_pkg.sv
// Shared encodings for the multiply/divide unit.
// Op codes, FSM states and small decode helpers.
package multiply_divide_unit_pkg;

  localparam int MDU_OP_WIDTH = 3;

  typedef enum logic [MDU_OP_WIDTH-1:0] {
    MDU_OP_NONE  = 3'd0,
    MDU_OP_MULT  = 3'd1,
    MDU_OP_MULTU = 3'd2,
    MDU_OP_DIV   = 3'd3,
    MDU_OP_DIVU  = 3'd4,
    MDU_OP_MTHI  = 3'd5,
    MDU_OP_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_FIN  = 2'd3
  } mdu_state_e;

  function automatic logic op_is_mul(
    input logic [MDU_OP_WIDTH-1:0] op
  );
    return (op == MDU_OP_MULT) ||
           (op == MDU_OP_MULTU);
  endfunction

  function automatic logic op_is_div(
    input logic [MDU_OP_WIDTH-1:0] op
  );
    return (op == MDU_OP_DIV) ||
           (op == MDU_OP_DIVU);
  endfunction

  function automatic logic op_is_signed(
    input logic [MDU_OP_WIDTH-1:0] op
  );
    return (op == MDU_OP_MULT) ||
           (op == MDU_OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_divider_core.sv
// Restoring divider on unsigned magnitudes,
// one quotient bit per step.
module mdu_divider_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0] quo_q;
  logic [W-1:0] rem_q;
  logic [W-1:0] dvs_q;
  logic [W:0]   trial;

  // Bit W set means the trial subtraction borrowed.
  assign trial = {rem_q, quo_q[W-1]} - {1'b0, dvs_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      if (!trial[W]) begin
        rem_q <= trial[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b1};
      end else begin
        rem_q <= {rem_q[W-2:0], quo_q[W-1]};
        quo_q <= {quo_q[W-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/multiply_divide_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO.
// Shift-add multiply, restoring divide, one bit per cycle.
module multiply_divide_unit
  import multiply_divide_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    start,
  input  logic [MDU_OP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]   rs,
  input  logic [DATA_WIDTH-1:0]   rt,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   hi,
  output logic [DATA_WIDTH-1:0]   lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  mdu_state_e     state_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   rs_q;
  logic [2*W-1:0] prod_q;
  logic [2*W-1:0] prod_d;
  logic           neg_q;
  logic           rneg_q;
  logic           dz_q;
  logic           mul_q;

  logic [W:0]     psum;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W-1:0]   hi_d;
  logic [W-1:0]   lo_d;
  logic           accept;
  logic           div_load;
  logic           div_step;

  assign a_neg = op_is_signed(op) & rs[W-1];
  assign b_neg = op_is_signed(op) & rt[W-1];
  assign a_mag = a_neg ? -rs : rs;
  assign b_mag = b_neg ? -rt : rt;

  assign accept = (state_q == MDU_IDLE) & start
                & ~stall & ~flush;
  assign div_load = accept & op_is_div(op);
  assign div_step = (state_q == MDU_DIV)
                  & ~stall & ~flush;

  // Multiplier sits in the low half and shifts out.
  assign psum = {1'b0, prod_q[2*W-1:W]}
              + (prod_q[0] ? {1'b0, a_q} : '0);
  assign prod_d = {psum, prod_q[W-1:1]};

  mdu_divider_core #(
    .DATA_WIDTH (W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (div_step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    unique case (1'b1)
      mul_q: {hi_d, lo_d} = neg_q ? -prod_q : prod_q;
      dz_q: begin
        hi_d = rs_q;
        lo_d = '1;
      end
      default: begin
        lo_d = neg_q  ? -quo : quo;
        hi_d = rneg_q ? -rem : rem;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      rs_q    <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      mul_q   <= 1'b0;
    end else if (flush) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!stall) begin
      done_q <= 1'b0;
      case (state_q)
        MDU_IDLE: begin
          if (start) begin
            if (op_is_mul(op)) begin
              state_q <= MDU_MUL;
              a_q     <= a_mag;
              prod_q  <= {{W{1'b0}}, b_mag};
              neg_q   <= a_neg ^ b_neg;
              mul_q   <= 1'b1;
              dz_q    <= 1'b0;
              cnt_q   <= '0;
            end else if (op_is_div(op)) begin
              state_q <= MDU_DIV;
              neg_q   <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
              dz_q    <= (rt == '0);
              rs_q    <= rs;
              mul_q   <= 1'b0;
              cnt_q   <= '0;
            end else if (op == MDU_OP_MTHI) begin
              hi_q   <= rs;
              done_q <= 1'b1;
            end else if (op == MDU_OP_MTLO) begin
              lo_q   <= rs;
              done_q <= 1'b1;
            end
          end
        end
        MDU_MUL, MDU_DIV: begin
          busy_q <= 1'b1;
          cnt_q  <= cnt_q + 1'b1;
          if (state_q == MDU_MUL)
            prod_q <= prod_d;
          if (cnt_q == LAST)
            state_q <= MDU_FIN;
        end
        MDU_FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          state_q <= MDU_IDLE;
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Bench for multiply_divide_unit: directed literals plus
// randomized traffic against a cycle-count reference model.
module tb_multiply_divide_unit;
  import multiply_divide_unit_pkg::*;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        stall8 = 1'b0;
  logic        flush8 = 1'b0;
  logic        start8 = 1'b0;
  logic [2:0]  op8 = 3'd0;
  logic [7:0]  rs8 = '0;
  logic [7:0]  rt8 = '0;
  logic        busy8;
  logic        done8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  int checks = 0;
  int failures = 0;
  logic chk_on = 1'b0;

  logic        m_busy;
  logic        m_done;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_pend;
  int          m_k;
  logic [63:0] m_res;

  multiply_divide_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  multiply_divide_unit #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .stall(stall8), .flush(flush8),
    .start(start8), .op(op8), .rs(rs8), .rt(rt8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {hi,lo} straight from arithmetic definitions
  function automatic logic [63:0] ref_res(input logic [2:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == MDU_OP_MULT) return 64'(sa * sb);
    if (o == MDU_OP_MULTU) return {32'd0, a} * {32'd0, b};
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (o == MDU_OP_DIV) return {32'(sa % sb), 32'(sa / sb)};
    return {a % b, a / b};
  endfunction

  task automatic m_reset();
    m_busy = 1'b0; m_done = 1'b0;
    m_hi = '0; m_lo = '0;
    m_pend = 1'b0; m_k = 0; m_res = '0;
  endtask

  // One clock edge of the spec's timeline: result lands
  // W+1 un-stalled edges after accept, busy on edges 1..W.
  task automatic m_step();
    if (flush) begin
      m_pend = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    end else if (!stall) begin
      m_done = 1'b0;
      if (m_pend) begin
        m_k++;
        m_busy = (m_k <= W);
        if (m_k == W + 1) begin
          {m_hi, m_lo} = m_res;
          m_done = 1'b1;
          m_pend = 1'b0;
          m_busy = 1'b0;
        end
      end else if (start) begin
        if (op == MDU_OP_MULT || op == MDU_OP_MULTU ||
            op == MDU_OP_DIV || op == MDU_OP_DIVU) begin
          m_pend = 1'b1; m_k = 0;
          m_res = ref_res(op, rs, rt);
        end else if (op == MDU_OP_MTHI) begin
          m_hi = rs; m_done = 1'b1;
        end else if (op == MDU_OP_MTLO) begin
          m_lo = rs; m_done = 1'b1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic cyc();
    @(posedge clk);
    if (!rst) m_step();
    @(negedge clk);
  endtask

  task automatic go(input logic [2:0] o,
                    input logic [31:0] a,
                    input logic [31:0] b);
    op = o; rs = a; rt = b; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int bc);
    n = 0; bc = 0;
    while (done !== 1'b1 && n < 200) begin
      bc += int'(busy);
      cyc();
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic run8(input string name, input logic [2:0] o,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eh, input logic [7:0] el);
    int n;
    op8 = o; rs8 = a; rt8 = b; start8 = 1'b1;
    cyc();
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    chk({name, "_lat"}, 64'(n), 64'd9);
    chk({name, "_hi"}, 64'(hi8), 64'(eh));
    chk({name, "_lo"}, 64'(lo8), 64'(el));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return 32'($urandom());
    endcase
  endfunction

  initial begin
    int n, bc, seen;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst = 1'b0;
    chk_on = 1'b1;

    go(MDU_OP_MULT, -32'd3, 32'd7);
    wait_done(n, bc);
    chk("mult_lat", 64'(n), 64'd33);
    chk("mult_busy_cycles", 64'(bc), 64'd32);
    chk("mult_busy_at_done", 64'(busy), 64'd0);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);

    go(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done(n, bc);
    chk("multu_hi", 64'(hi), 64'd1);
    chk("multu_lo", 64'(lo), 64'hFFFF_FFFE);

    go(MDU_OP_DIV, -32'd7, 32'd2);
    wait_done(n, bc);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

    go(MDU_OP_DIVU, 32'd7, 32'd0);
    wait_done(n, bc);
    chk("divz_lo", 64'(lo), 64'hFFFF_FFFF);
    chk("divz_hi", 64'(hi), 64'd7);

    go(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, bc);
    chk("divmin_lo", 64'(lo), 64'h8000_0000);
    chk("divmin_hi", 64'(hi), 64'd0);

    go(MDU_OP_MTHI, 32'd5, 32'd0);
    chk("mthi_hi", 64'(hi), 64'd5);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd1);
    go(MDU_OP_MTLO, 32'd9, 32'd0);
    chk("mtlo_lo", 64'(lo), 64'd9);
    go(MDU_OP_DIV, 32'd100, 32'd7);
    repeat (2) cyc();
    go(MDU_OP_MTLO, 32'd123, 32'd0);
    chk("mtlo_busy_ign", 64'(lo), 64'd9);
    wait_done(n, bc);
    chk("div_after_mt_lo", 64'(lo), 64'd14);

    go(MDU_OP_DIVU, 32'd100, 32'd7);
    repeat (5) cyc();
    stall = 1'b1;
    repeat (10) cyc();
    stall = 1'b0;
    wait_done(n, bc);
    chk("stall_lat", 64'(n + 15), 64'd43);
    chk("stall_lo", 64'(lo), 64'd14);
    chk("stall_hi", 64'(hi), 64'd2);

    go(MDU_OP_DIVU, 32'd100, 32'd7);
    repeat (33) cyc();
    chk("done_at_fin", 64'(done), 64'd1);
    stall = 1'b1;
    repeat (3) begin
      cyc();
      chk("done_hold", 64'(done), 64'd1);
    end
    stall = 1'b0;
    cyc();
    chk("done_clear", 64'(done), 64'd0);

    go(MDU_OP_DIV, 32'd1000, 32'd3);
    repeat (4) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'd2);
    chk("flush_lo", 64'(lo), 64'd14);
    seen = 0;
    repeat (40) begin
      cyc();
      seen |= int'(done);
    end
    chk("flush_no_done", 64'(seen), 64'd0);

    flush = 1'b1;
    go(MDU_OP_MULT, 32'd3, 32'd3);
    flush = 1'b0;
    cyc();
    chk("flush_start_busy", 64'(busy), 64'd0);

    go(MDU_OP_MULT, 32'd5, 32'd6);
    repeat (10) cyc();
    #2 rst = 1'b1;
    m_reset();
    #1;
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run8("m8_ffff", MDU_OP_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01);
    run8("d8_neg", MDU_OP_DIV, 8'hF9, 8'h02, 8'hFF, 8'hFD);
    run8("m8_min", MDU_OP_MULT, 8'h80, 8'h80, 8'h40, 8'h00);

    repeat (3000) begin
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 39) == 0);
      start = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      rs = pick();
      rt = pick();
      cyc();
    end
    stall = 1'b0;
    flush = 1'b0;
    start = 1'b0;
    repeat (40) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
